// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  // Front-end sequencing state.
  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } pc_state_e;

  // mtvec MODE field encodings; values 2 and 3 behave as direct.
  localparam logic [1:0] MtvecModeDirect   = 2'b00;
  localparam logic [1:0] MtvecModeVectored = 2'b01;

  // Sequential fetch stride in bytes.
  localparam int unsigned PcIncr = 4;

  localparam logic [31:0] DefaultResetPc = 32'h8000_0000;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer. Combinational read, registered write.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IdxBits = $clog2(BTB_ENTRIES);
  localparam int unsigned IdxW    = (IdxBits > 0) ? IdxBits : 1;
  localparam int unsigned TagW    = XLEN - IdxBits - 2;

  function automatic logic [IdxW-1:0] idx_of(input logic [XLEN-1:0] pc);
    if (IdxBits == 0) return '0;
    return IdxW'(pc >> 2);
  endfunction

  function automatic logic [TagW-1:0] tag_of(input logic [XLEN-1:0] pc);
    return TagW'(pc >> (IdxBits + 2));
  endfunction

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]        tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] wr_tag;
  logic            wr_fill;

  assign rd_idx  = idx_of(rd_pc_i);
  assign wr_idx  = idx_of(upd_pc_i);
  assign wr_tag  = tag_of(upd_pc_i);
  assign wr_fill = upd_valid_i && upd_taken_i;

  // Lookup sees the registered contents, so a same-cycle write is not forwarded.
  always_comb begin
    rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == tag_of(rd_pc_i));
    rd_target_o = target_q[rd_idx];
  end

  // Valid bits: set on taken update, cleared on not-taken update to a matching entry.
  always_comb begin
    valid_d = valid_q;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        valid_d[wr_idx] = 1'b1;
      end else if (valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) begin
        valid_d[wr_idx] = 1'b0;
      end
    end
  end

  // Valid bits are the only reset state; tag/target are qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and target payload storage, written only on a taken update.
  always_ff @(posedge clk) begin
    if (wr_fill) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator: boot/run/halt sequencing, prioritized
// redirects, vectored trap entry and optional BTB-based next-PC prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DefaultResetPc),
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            fetch_pred_taken_o,
  input  logic            exception_en_i,
  input  logic            exception_is_intr_i,
  input  logic [4:0]      exception_cause_i,
  input  logic [XLEN-1:0] mtvec_rdata_i,
  input  logic            mret_en_i,
  input  logic [XLEN-1:0] mepc_rdata_i,
  input  logic            jump_taken_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            halt_en_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic            halted_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            btb_hit;
  logic [XLEN-1:0] btb_target;
  logic [XLEN-1:0] trap_base, trap_target;

  // Low alignment bits are discarded by the redirect paths.
  logic unused_align;
  assign unused_align = ^{mepc_rdata_i[1:0], jump_target_i[0]};

  if (BTB_ENTRIES > 0) begin : g_btb
    pc_btb #(
      .XLEN       (XLEN),
      .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_pc_i     (pc_q),
      .rd_hit_o    (btb_hit),
      .rd_target_o (btb_target),
      .upd_valid_i (upd_valid_i),
      .upd_pc_i    (upd_pc_i),
      .upd_taken_i (upd_taken_i),
      .upd_target_i(upd_target_i)
    );
  end else begin : g_no_btb
    logic unused_upd;
    assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
  end

  // Outputs decode directly from the state register.
  always_comb begin
    fetch_valid_o      = (state_q == StRun);
    halted_o           = (state_q == StHalt);
    fetch_pc_o         = pc_q;
    fetch_pred_taken_o = btb_hit && fetch_valid_o;
  end

  // Trap target: direct base, or base + 4*cause for vectored interrupts.
  always_comb begin
    trap_base   = {mtvec_rdata_i[XLEN-1:2], 2'b00};
    trap_target = trap_base;
    if (VECTORED_EN && (mtvec_rdata_i[1:0] == MtvecModeVectored) && exception_is_intr_i) begin
      trap_target = trap_base + (XLEN'(exception_cause_i) << 2);
    end
  end

  // Next state and next PC; redirects are only honoured while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_en_i) begin
          state_d = StHalt;
        end else if (exception_en_i) begin
          pc_d = trap_target;
        end else if (mret_en_i) begin
          pc_d = {mepc_rdata_i[XLEN-1:2], 2'b00};
        end else if (jump_taken_i) begin
          pc_d = {jump_target_i[XLEN-1:1], 1'b0};
        end else if (fetch_ready_i) begin
          pc_d = fetch_pred_taken_o ? btb_target : pc_q + XLEN'(PcIncr);
        end
      end
      StHalt: ;
      default: state_d = StBoot;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] ResetPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready, fetch_pred_taken;
  logic [31:0] fetch_pc;
  logic        exception_en, exception_is_intr;
  logic [4:0]  exception_cause;
  logic [31:0] mtvec_rdata, mepc_rdata, jump_target, upd_pc, upd_target;
  logic        mret_en, jump_taken, halt_en, upd_valid, upd_taken, halted;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = boot, 1 = run, 2 = halt.
  int          m_state;
  logic [31:0] m_pc;
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_valid_o      (fetch_valid),
    .fetch_ready_i      (fetch_ready),
    .fetch_pc_o         (fetch_pc),
    .fetch_pred_taken_o (fetch_pred_taken),
    .exception_en_i     (exception_en),
    .exception_is_intr_i(exception_is_intr),
    .exception_cause_i  (exception_cause),
    .mtvec_rdata_i      (mtvec_rdata),
    .mret_en_i          (mret_en),
    .mepc_rdata_i       (mepc_rdata),
    .jump_taken_i       (jump_taken),
    .jump_target_i      (jump_target),
    .halt_en_i          (halt_en),
    .upd_valid_i        (upd_valid),
    .upd_pc_i           (upd_pc),
    .upd_taken_i        (upd_taken),
    .upd_target_i       (upd_target),
    .halted_o           (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = ResetPc;
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endtask

  // One clock edge of the behavioural model, using the currently driven inputs.
  task automatic model_step();
    logic [31:0] base;
    bit          pred;
    int unsigned ui;
    pred = (m_state == 1) && m_hit(m_pc);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (halt_en) begin
        m_state = 2;
      end else if (exception_en) begin
        base = mtvec_rdata - (mtvec_rdata % 4);
        if ((mtvec_rdata % 4 == 1) && exception_is_intr) m_pc = base + 32'(exception_cause) * 4;
        else m_pc = base;
      end else if (mret_en) begin
        m_pc = mepc_rdata - (mepc_rdata % 4);
      end else if (jump_taken) begin
        m_pc = jump_target - (jump_target % 2);
      end else if (fetch_ready) begin
        m_pc = pred ? m_tgt[m_idx(m_pc)] : m_pc + 4;
      end
    end
    if (upd_valid) begin
      ui = m_idx(upd_pc);
      if (upd_taken) begin
        m_valid[ui] = 1;
        m_tag[ui]   = upd_pc / 64;
        m_tgt[ui]   = upd_target;
      end else if (m_valid[ui] && m_tag[ui] == upd_pc / 64) begin
        m_valid[ui] = 0;
      end
    end
  endtask

  task automatic compare();
    check("fetch_valid", 32'(fetch_valid), 32'(m_state == 1));
    check("halted", 32'(halted), 32'(m_state == 2));
    check("fetch_pc", fetch_pc, m_pc);
    check("fetch_pred_taken", 32'(fetch_pred_taken), 32'((m_state == 1) && m_hit(m_pc)));
  endtask

  // Inputs are driven before calling; outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_inputs();
    fetch_ready = 1'b1;
    exception_en = 1'b0; exception_is_intr = 1'b0; exception_cause = '0;
    mtvec_rdata = '0; mret_en = 1'b0; mepc_rdata = '0;
    jump_taken = 1'b0; jump_target = '0; halt_en = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_pc", fetch_pc, ResetPc);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pred", 32'(fetch_pred_taken), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare();
    check("boot_no_valid", 32'(fetch_valid), 32'd0);

    // Sequential fetch after reset release.
    cycle(); check("seq_pc0", fetch_pc, 32'h8000_0000); check("seq_valid", 32'(fetch_valid), 32'd1);
    cycle(); check("seq_pc1", fetch_pc, 32'h8000_0004);
    cycle(); check("seq_pc2", fetch_pc, 32'h8000_0008);
    cycle(); cycle(); check("seq_pc4", fetch_pc, 32'h8000_0010);

    // Backpressure.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("stall_pc", fetch_pc, 32'h8000_0010);
    end
    fetch_ready = 1'b1;
    cycle(); check("stall_release", fetch_pc, 32'h8000_0014);

    // Redirect priority, then halt beating all redirects.
    exception_en = 1'b1; mret_en = 1'b1; jump_taken = 1'b1;
    mtvec_rdata = 32'h8000_1000; mepc_rdata = 32'h8000_2002; jump_target = 32'h8000_3003;
    cycle(); check("prio_trap", fetch_pc, 32'h8000_1000);
    halt_en = 1'b1;
    cycle(); check("halt_pc", fetch_pc, 32'h8000_1000); check("halt_flag", 32'(halted), 32'd1);
    check("halt_no_valid", 32'(fetch_valid), 32'd0);
    clear_inputs();
    jump_taken = 1'b1; jump_target = 32'h8000_4000;
    cycle(); check("halt_sticky", fetch_pc, 32'h8000_1000);
    clear_inputs();
    do_reset();

    // Vectored trap entry.
    cycle();
    exception_en = 1'b1; mtvec_rdata = 32'h8000_1001; exception_is_intr = 1'b1; exception_cause = 5'd7;
    cycle(); check("vec_intr", fetch_pc, 32'h8000_101C);
    exception_is_intr = 1'b0;
    cycle(); check("vec_exc", fetch_pc, 32'h8000_1000);
    clear_inputs();
    do_reset();

    // BTB training and untraining.
    cycle();
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h8000_0008; upd_target = 32'h8000_0100;
    cycle(); clear_inputs();
    cycle(); check("btb_pc", fetch_pc, 32'h8000_0008); check("btb_pred", 32'(fetch_pred_taken), 32'd1);
    cycle(); check("btb_target", fetch_pc, 32'h8000_0100);
    upd_valid = 1'b1; upd_taken = 1'b0; upd_pc = 32'h8000_0008;
    jump_taken = 1'b1; jump_target = 32'h8000_0008;
    cycle(); clear_inputs();
    check("untrain_pc", fetch_pc, 32'h8000_0008); check("untrain_pred", 32'(fetch_pred_taken), 32'd0);
    cycle(); check("untrain_next", fetch_pc, 32'h8000_000C);

    // Reset while an entry is valid clears the BTB.
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h8000_0008; upd_target = 32'h8000_0100;
    cycle(); clear_inputs();
    do_reset();
    cycle(); cycle(); cycle();
    check("post_rst_pc", fetch_pc, 32'h8000_0008); check("post_rst_pred", 32'(fetch_pred_taken), 32'd0);
    cycle(); check("post_rst_next", fetch_pc, 32'h8000_000C);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ((m_state == 2 && $urandom_range(3) == 0) || $urandom_range(499) == 0) begin
        clear_inputs();
        do_reset();
      end
      fetch_ready       = ($urandom_range(3) != 0);
      exception_en      = ($urandom_range(19) == 0);
      exception_is_intr = 1'($urandom);
      exception_cause   = 5'($urandom);
      mtvec_rdata       = 32'h8000_0000 + ($urandom_range(63) * 4) + $urandom_range(3);
      mret_en           = ($urandom_range(24) == 0);
      mepc_rdata        = 32'h8000_0000 + $urandom_range(255);
      jump_taken        = ($urandom_range(9) == 0);
      jump_target       = 32'h8000_0000 + $urandom_range(255);
      halt_en           = ($urandom_range(149) == 0);
      upd_valid         = ($urandom_range(2) == 0);
      upd_taken         = 1'($urandom);
      upd_pc            = 32'h8000_0000 + $urandom_range(63) * 4;
      upd_target        = 32'h8000_0000 + $urandom_range(63) * 4;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
